// File: rtl/mem_responder.sv
// Single-port byte memory terminating the control unit's req/ack bus, with
// programmable wait states. Optional write lock below ROM_TOP: MEM_RESPONDER_WRITE_LOCK_EN.
module mem_responder #(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] ROM_TOP     = 8'h40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef MEM_RESPONDER_WRITE_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                enter_resp;
    logic                write_locked;
    logic                commit;

    logic [7:0]          mem [DEPTH];

    // The *_d request fields are the transaction's own values on the RESP-entry
    // edge in both paths: freshly captured (no wait states) or held from accept.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign write_locked = LOCK_EN && (addr_d < ROM_TOP);
    assign commit       = enter_resp && we_d && !write_locked;

    always_comb begin
        rdata_d = rdata_q;
        if (enter_resp && !we_d) begin
            rdata_d = mem[addr_d];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the storage array has no reset so it maps onto RAM; contents
    // survive reset, and a write is blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (commit && reset) begin
            mem[addr_d] <= wdata_d;
        end
    end

    assign rdata = rdata_q;
    assign ack   = (state_q == RESP);
    assign busy  = (state_q != IDLE);

`ifdef MEM_RESPONDER_WRITE_LOCK_EN
    assign err = (state_q == RESP) && we_q && (addr_q < ROM_TOP);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with one wait state and
// one with none, both checked against a per-address reference memory.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_v   [2];
    logic       we_v    [2];
    logic [7:0] addr_v  [2];
    logic [7:0] wdata_v [2];
    logic [7:0] rdata_v [2];
    logic       ack_v   [2];
    logic       busy_v  [2];
    logic       err_v   [2];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1), .ROM_TOP(8'h40)) u_dut (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ack(ack_v[0]), .busy(busy_v[0]), .err(err_v[0])
    );

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0), .ROM_TOP(8'h40)) u_dut0 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ack(ack_v[1]), .busy(busy_v[1]), .err(err_v[1])
    );

`ifdef MEM_RESPONDER_WRITE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] ref_mem  [2][256];
    bit         known    [2][256];
    logic [7:0] rd_exp   [2];
    bit         rd_known [2];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int u, input string tag);
        chk({tag, "_ack"},  8'(ack_v[u]),  8'h00);
        chk({tag, "_busy"}, 8'(busy_v[u]), 8'h00);
        chk({tag, "_err"},  8'(err_v[u]),  8'h00);
        if (rd_known[u]) chk({tag, "_rdata"}, rdata_v[u], rd_exp[u]);
    endtask

    // One complete transaction, entered and left at a negedge with the DUT idle.
    // Request fields are scrambled after accept; the DUT must ignore that.
    task automatic txn(input int u, input bit w, input logic [7:0] a, input logic [7:0] d);
        int wc = (u == 0) ? 1 : 0;
        bit lk = LOCK && w && (a < 8'h40);
        req_v[u] = 1'b1; we_v[u] = w; addr_v[u] = a; wdata_v[u] = d;
        @(posedge clk); #1;
        we_v[u] = 1'($urandom); addr_v[u] = 8'($urandom); wdata_v[u] = 8'($urandom);
        if (w && !lk) begin
            ref_mem[u][a] = d;
            known[u][a]   = 1'b1;
        end else if (!w) begin
            rd_known[u] = known[u][a];
            rd_exp[u]   = ref_mem[u][a];
        end
        for (int c = 1; c <= wc + 1; c++) begin
            @(negedge clk);
            chk("txn_busy", 8'(busy_v[u]), 8'h01);
            chk("txn_ack",  8'(ack_v[u]),  8'(c == wc + 1));
        end
        chk("txn_err", 8'(err_v[u]), 8'(lk));
        if (rd_known[u]) chk("txn_rdata", rdata_v[u], rd_exp[u]);
        req_v[u] = 1'b0;
        @(negedge clk);
        chk_idle(u, "post");
    endtask

    initial begin
        int k;
        bit exp_ack;
        for (int u = 0; u < 2; u++) begin
            req_v[u] = 1'b0; we_v[u] = 1'b0; addr_v[u] = 8'h00; wdata_v[u] = 8'h00;
            rd_exp[u] = 8'h00; rd_known[u] = 1'b1;
            for (int i = 0; i < 256; i++) known[u][i] = 1'b0;
        end

        // Reset held three cycles, then idle.
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle(0, "rst"); chk_idle(1, "rst");
        end
        @(posedge clk); #1 reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_idle(0, "idle"); chk_idle(1, "idle");
        end

        // Write then read back, one wait state and zero wait states.
        txn(0, 1'b1, 8'h80, 8'hA5);
        txn(0, 1'b0, 8'h80, 8'h00);
        chk("raw_w1", rdata_v[0], 8'hA5);
        txn(1, 1'b1, 8'h80, 8'h5A);
        txn(1, 1'b0, 8'h80, 8'h00);
        chk("raw_w0", rdata_v[1], 8'h5A);

        // Back-to-back reads with req held: ack every third cycle.
        for (int i = 0; i < 4; i++) txn(0, 1'b1, 8'(8'h80 + i), 8'($urandom));
        k = 0;
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 8'h80;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            exp_ack = (c % 3 == 2);
            chk("b2b_ack",  8'(ack_v[0]),  8'(exp_ack));
            chk("b2b_busy", 8'(busy_v[0]), 8'(c % 3 != 0));
            if (exp_ack && k < 4) begin
                chk("b2b_rdata", rdata_v[0], ref_mem[0][8'(8'h80 + k)]);
                k++;
                addr_v[0] = 8'(8'h80 + k);
                if (k == 4) req_v[0] = 1'b0;
            end
        end
        rd_exp[0] = ref_mem[0][8'h83]; rd_known[0] = 1'b1;

        // Reset during WAIT drops the pending write.
        txn(0, 1'b1, 8'h90, 8'h11);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 8'h90; wdata_v[0] = 8'h3C;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_wait_busy", 8'(busy_v[0]), 8'h01);
        reset = 1'b0; req_v[0] = 1'b0;
        #1;
        chk("midrst_ack",  8'(ack_v[0]),  8'h00);
        chk("midrst_busy", 8'(busy_v[0]), 8'h00);
        @(negedge clk);
        chk("midrst_ack2", 8'(ack_v[0]), 8'h00);
        @(posedge clk); #1 reset = 1'b1;
        for (int u = 0; u < 2; u++) begin rd_exp[u] = 8'h00; rd_known[u] = 1'b1; end
        @(negedge clk);
        chk_idle(0, "midrst_idle");
        txn(0, 1'b0, 8'h90, 8'h00);
        chk("midrst_old", rdata_v[0], 8'h11);

        // Write-lock boundary (err and commit depend on the build).
        txn(0, 1'b1, 8'h10, 8'hFF);
        txn(0, 1'b0, 8'h10, 8'h00);
        txn(0, 1'b1, 8'h40, 8'hFF);
        txn(0, 1'b0, 8'h40, 8'h00);
        chk("lock_edge", rdata_v[0], 8'hFF);

        // Random traffic around the lock boundary on both instances.
        for (int i = 0; i < 40; i++) begin
            txn(i % 3 == 2 ? 1 : 0, 1'($urandom), 8'(8'h30 + $urandom_range(0, 31)), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
